// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
//   div_state_t  : control FSM state encoding (IDLE, BUSY, DONE)
//   QuotAllOnes  : wide all-ones pattern; the top slices off N bits to form the
//                  quotient reported for a zero divisor
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    localparam logic [63:0] QuotAllOnes = '1;

endpackage

// File: rtl/trial_subtractor.sv
// Combinational W-bit subtractor o_diff = i_a - i_b with borrow-out.
// Per-bit propagate/generate borrow terms mirror the CLA adder datapath.
//   i_a      [W-1:0]  minuend
//   i_b      [W-1:0]  subtrahend
//   o_diff   [W-1:0]  i_a - i_b modulo 2^W
//   o_borrow          1 when i_a < i_b (unsigned)
module trial_subtractor #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic         o_borrow
);

    logic [W-1:0] w_x;  // half-difference a ^ b
    logic [W-1:0] w_p;  // borrow propagates through bit i (a_i == b_i)
    logic [W-1:0] w_g;  // borrow generated at bit i (a_i = 0, b_i = 1)

    for (genvar gi = 0; gi < W; gi++) begin : g_pg
        assign w_x[gi] = i_a[gi] ^ i_b[gi];
        assign w_p[gi] = ~w_x[gi];
        assign w_g[gi] = ~i_a[gi] & i_b[gi];
    end

    // Borrow chain kept in a block-local variable so the carry path is not a
    // self-referencing vector.
    always_comb begin
        logic v_borrow;
        v_borrow = 1'b0;
        o_diff   = '0;
        for (int i = 0; i < W; i++) begin
            o_diff[i] = w_x[i] ^ v_borrow;
            v_borrow  = w_g[i] | (w_p[i] & v_borrow);
        end
        o_borrow = v_borrow;
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned N-bit restoring divider, one quotient bit per clock.
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_in_valid / o_in_ready  request handshake; operands sampled on it
//   i_dividend, i_divisor    N-bit unsigned operands
//   o_out_valid / i_out_ready result handshake
//   o_quotient, o_remainder  N-bit results, held until the next result
//   o_div_by_zero            result came from a zero divisor
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic         o_div_by_zero
);

    localparam int unsigned      CntW     = $clog2(N);
    localparam logic [CntW-1:0]  CntInit  = CntW'(N - 1);
    localparam logic [N-1:0]     QuotOnes = QuotAllOnes[N-1:0];

    div_state_t      r_state;
    div_state_t      w_state_d;

    logic [N-1:0]    r_q;         // dividend shifting out, quotient shifting in
    logic [N-1:0]    r_d;         // latched divisor
    logic [N:0]      r_r;         // partial remainder
    logic [CntW-1:0] r_cnt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [N-1:0]    r_quotient;
    logic [N-1:0]    r_remainder;
    logic            r_div_by_zero;

    logic [N:0]      w_r_shift;
    logic [N:0]      w_trial;
    logic            w_borrow;
    logic [N:0]      w_r_next;
    logic [N-1:0]    w_q_next;
    logic            w_accept;
    logic            w_zero_div;
    logic            w_unused_r_msb;

    // The partial remainder always stays below the divisor, so its top bit is
    // zero entering each iteration and only the low N bits shift up.
    assign w_unused_r_msb = r_r[N];

    assign w_r_shift = {r_r[N-1:0], r_q[N-1]};

    trial_subtractor #(
        .W (N + 1)
    ) u_trial (
        .i_a      (w_r_shift),
        .i_b      ({1'b0, r_d}),
        .o_diff   (w_trial),
        .o_borrow (w_borrow)
    );

    // Restore on borrow: keep the shifted remainder and retire a 0 bit.
    assign w_r_next = w_borrow ? w_r_shift : w_trial;
    assign w_q_next = {r_q[N-2:0], ~w_borrow};

    assign w_accept   = (r_state == IDLE) && i_in_valid;
    assign w_zero_div = (i_divisor == '0);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_in_valid) begin
                    w_state_d = w_zero_div ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                if (i_out_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Handshake flags are registered copies of the next state so the ports
    // come straight from flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_d == IDLE);
            r_out_valid <= (w_state_d == DONE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q           <= '0;
            r_d           <= '0;
            r_r           <= '0;
            r_cnt         <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_q   <= i_dividend;
            r_d   <= i_divisor;
            r_r   <= '0;
            r_cnt <= CntInit;
            if (w_zero_div) begin
                r_quotient    <= QuotOnes;
                r_remainder   <= i_dividend;
                r_div_by_zero <= 1'b1;
            end
        end else if (r_state == BUSY) begin
            r_q   <= w_q_next;
            r_r   <= w_r_next;
            r_cnt <= r_cnt - CntW'(1);
            if (r_cnt == '0) begin
                r_quotient    <= w_q_next;
                r_remainder   <= w_r_next[N-1:0];
                r_div_by_zero <= 1'b0;
            end
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_out_valid   = r_out_valid;
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases, backpressure,
// mid-operation reset and randomized back-to-back traffic against a plain
// arithmetic reference (a / b, a % b).
module tb_seq_restoring_divider;

    localparam int N = 8;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [N-1:0] i_dividend;
    logic [N-1:0] i_divisor;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [N-1:0] o_quotient;
    logic [N-1:0] o_remainder;
    logic         o_div_by_zero;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    seq_restoring_divider #(
        .N (N)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full transaction starting at a negedge with the DUT idle.
    // hold >= 0: out_ready held low for exactly hold DONE cycles.
    // hold <  0: out_ready randomized each DONE cycle.
    task automatic run_op(input int a, input int b, input int hold);
        int exp_q, exp_r, exp_z, exp_lat;
        int lat, stalls, acc, cap;
        bit rdy, done;
        if (b == 0) begin
            exp_q = (1 << N) - 1;
            exp_r = a;
            exp_z = 1;
            exp_lat = 1;
        end else begin
            exp_q = a / b;
            exp_r = a % b;
            exp_z = 0;
            exp_lat = N + 1;
        end
        cap = (hold < 0) ? 20 : hold;

        check_eq("in_ready_idle", o_in_ready, 1);
        i_in_valid = 1'b1;
        i_dividend = N'(a);
        i_divisor  = N'(b);
        @(posedge i_clk);
        @(negedge i_clk);
        acc = cyc;
        lat = 1;
        while (!o_out_valid && lat < 40) begin
            // Requests while busy must be ignored.
            i_in_valid = 1'($urandom_range(0, 1));
            i_dividend = N'($urandom);
            i_divisor  = N'($urandom);
            check_eq("in_ready_busy", o_in_ready, 0);
            @(negedge i_clk);
            lat++;
        end
        check_eq("latency", lat, exp_lat);
        check_eq("quotient", o_quotient, exp_q);
        check_eq("remainder", o_remainder, exp_r);
        check_eq("div_by_zero", o_div_by_zero, exp_z);
        if (b != 0) begin
            check_eq("invariant", o_quotient * b + o_remainder, a);
            check_eq("rem_lt_div", (o_remainder < b), 1);
        end

        stalls = 0;
        done = 1'b0;
        while (!done) begin
            if (hold >= 0) rdy = (stalls >= hold);
            else rdy = ($urandom_range(0, 2) != 0) || (stalls >= cap);
            i_out_ready = rdy;
            i_in_valid  = 1'($urandom_range(0, 1));
            i_dividend  = N'($urandom);
            i_divisor   = N'($urandom);
            @(posedge i_clk);
            if (rdy) begin
                done = 1'b1;
            end else begin
                @(negedge i_clk);
                stalls++;
                check_eq("hold_valid", o_out_valid, 1);
                check_eq("hold_in_ready", o_in_ready, 0);
                check_eq("hold_quotient", o_quotient, exp_q);
                check_eq("hold_remainder", o_remainder, exp_r);
                check_eq("hold_dbz", o_div_by_zero, exp_z);
            end
        end
        @(negedge i_clk);
        i_out_ready = 1'b0;
        i_in_valid  = 1'b0;
        check_eq("valid_cleared", o_out_valid, 0);
        check_eq("in_ready_after", o_in_ready, 1);
        // Earliest next accept is the edge ending this cycle.
        check_eq("period", cyc - acc + 1, exp_lat + 1 + stalls);
    endtask

    initial begin
        int a, b, sel;
        i_rst_n     = 1'b0;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b0;
        i_dividend  = '0;
        i_divisor   = '0;
        repeat (2) @(negedge i_clk);
        check_eq("rst_in_ready", o_in_ready, 1);
        check_eq("rst_out_valid", o_out_valid, 0);
        check_eq("rst_quotient", o_quotient, 0);
        check_eq("rst_remainder", o_remainder, 0);
        check_eq("rst_dbz", o_div_by_zero, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run_op(100, 7, 0);
        run_op(255, 1, 0);
        run_op(5, 9, 0);
        run_op(200, 200, 0);
        run_op(37, 0, 0);
        run_op(100, 7, 6);

        // Reset during the 4th BUSY cycle of 250/3.
        i_in_valid = 1'b1;
        i_dividend = N'(250);
        i_divisor  = N'(3);
        @(posedge i_clk);
        @(negedge i_clk);
        i_in_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check_eq("midrst_quotient", o_quotient, 0);
        check_eq("midrst_remainder", o_remainder, 0);
        check_eq("midrst_dbz", o_div_by_zero, 0);
        check_eq("midrst_valid", o_out_valid, 0);
        check_eq("midrst_in_ready", o_in_ready, 1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            check_eq("no_stale_valid", o_out_valid, 0);
        end
        i_out_ready = 1'b0;
        check_eq("postrst_in_ready", o_in_ready, 1);
        run_op(9, 4, 0);

        for (int k = 0; k < 1000; k++) begin
            a = $urandom_range(0, (1 << N) - 1);
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 0;
            else if (sel < 4) b = $urandom_range(1, 15);
            else b = $urandom_range(1, (1 << N) - 1);
            run_op(a, b, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned N-bit integer divider; the subtract-and-shift inverse of the CLA adder datapath.
- Retires one quotient bit per clock using a single shared N+1-bit trial subtractor.
- Sits behind a valid/ready request interface and a valid/ready result interface.
- Used wherever the arithmetic library needs quotient/remainder without a large combinational array.

Parameters:
N  8  operand width in bits (N >= 2); dividend, divisor, quotient and remainder are all N bits.

Ports:
clk          input   1  single clock, all state updates on rising edge
rst_n        input   1  asynchronous active-low reset
in_valid     input   1  request valid
in_ready     output  1  request accepted when in_valid & in_ready at rising edge
dividend     input   N  unsigned dividend, sampled on request handshake
divisor      input   N  unsigned divisor, sampled on request handshake
out_valid    output  1  result valid
out_ready    input   1  result consumed when out_valid & out_ready at rising edge
quotient     output  N  unsigned quotient
remainder    output  N  unsigned remainder
div_by_zero  output  1  result was produced from a zero divisor

Behaviour:
- Reset (asynchronous, rst_n low): FSM to IDLE; in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0; all internal registers cleared. Reset takes effect mid-operation and discards any in-flight division. No result is emitted for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On handshake, latch dividend into Q-shift reg, divisor into D, clear partial remainder R (N+1 bits), load iteration counter=N-1.
  - If divisor!=0, go to BUSY.
  - If divisor==0, go directly to DONE with quotient={N{1'b1}}, remainder=dividend, div_by_zero=1.
- BUSY (in_ready=0), each cycle:
  - R' = {R[N-1:0], Q[N-1]}; Q shifts left.
  - trial = R' - {1'b0,D} (N+1 bits).
  - If no borrow: R=trial[N:0] and Q[0]=1. Else R=R' and Q[0]=0.
  - The counter decrements. When the counter is 0 at the edge, go to DONE.
- BUSY lasts exactly N cycles. out_valid rises N+1 cycles after the accepting edge (divisor!=0), or 1 cycle after it (divisor==0).
- DONE: out_valid=1, quotient=Q, remainder=R[N-1:0], div_by_zero as latched.
  - Outputs stay stable while out_ready=0 (backpressure of any length).
  - On output handshake, go to IDLE and clear out_valid. in_ready rises in the same cycle.
  - No input/output overlap: in_ready=0 in DONE, so back-to-back throughput is one division per N+2 cycles.
- quotient/remainder/div_by_zero hold their last values after leaving DONE until the next result is loaded. They are don't-care for checking whenever out_valid=0.
- Inputs dividend/divisor may change freely outside the request handshake. in_valid while in_ready=0 is ignored (not queued).
- Invariant on every result with divisor!=0: dividend == quotient*divisor + remainder and remainder < divisor.
- No X propagation: all outputs are driven from registers.

Decomposition:
- Package div_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
  - localparam for the all-ones quotient value used on divide-by-zero.
- Sub-module trial_subtractor #(W): combinational W-bit a-b producing diff and borrow_out. It is built from generate-loop propagate/generate borrow logic in the same style as the CLA adder, instantiated with W=N+1.
- Counter width is $clog2(N).

Test Plan:
- N=8, 100/7: expect quotient=14, remainder=2, div_by_zero=0. out_valid rises exactly 9 cycles after the accepting edge.
- 255/1 -> quotient=255, remainder=0. 5/9 -> quotient=0, remainder=5. 200/200 -> quotient=1, remainder=0.
- 37/0 -> quotient=255, remainder=37, div_by_zero=1, out_valid 1 cycle after acceptance.
- Backpressure: 100/7 with out_ready=0 for 6 cycles. Outputs must be stable (14,2), in_ready=0, and in_valid pulses ignored. Handshake on cycle 7 must give in_ready=1 in that same cycle.
- Reset mid-op: start 250/3 and assert rst_n=0 during the 4th BUSY cycle. Outputs go to zero immediately. After release, in_ready=1, and a new 9/4 yields 2,1 with no stale result emitted.
- Random: 1000 back-to-back random pairs with random out_ready. Check the quotient/remainder invariant and the N+2-cycle throughput.
